// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit hex seven-segment scanner.
// Each scan-enable tick steps to the next digit. An optional all-dark gap of
// BLANK_CYCLES separates digits. The value is snapshotted once per frame.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN. When it is defined,
// leading zero digits are suppressed, always keeping digit 0.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                      fastclock,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp
);

  localparam int                    IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            BLANK_LOAD = (BLANK_CYCLES > 0) ? 8'(BLANK_CYCLES - 1) : 8'd0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF    = {7{ACTIVE_LOW}};
  localparam logic                  DP_OFF     = ACTIVE_LOW;

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BLANK} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   snap_q, snap_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      advance;

  logic [3:0]                nibs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     lz_blank;
  logic [NUM_DIGITS-1:0]     an_d;
  logic [6:0]                seg_d;
  logic                      dp_d;
  logic                      lit;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Split the snapshot into nibbles and work out per-digit leading-zero suppression.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibs[gi] = snap_q[4*gi +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else begin : g_msd
        assign lz_blank[gi] = ~|snap_q[4*NUM_DIGITS-1:4*gi];
      end
`else
      assign lz_blank[gi] = 1'b0;
`endif
    end
  endgenerate

  // Next-state logic: scan sequencing, gap countdown and per-frame snapshot.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_SHOW;
          idx_d   = '0;
          snap_d  = value;
        end
      end
      S_SHOW: begin
        if (tick) begin
          if (BLANK_CYCLES == 0) begin
            advance = 1'b1;
          end else begin
            state_d = S_BLANK;
            cnt_d   = BLANK_LOAD;
          end
        end
      end
      S_BLANK: begin
        // Ticks arriving here are dropped on purpose; only the countdown matters.
        if (cnt_q == 8'd0) begin
          advance = 1'b1;
          state_d = S_SHOW;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        snap_d = value;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Output decode from the current state; dp_in and blank are used live.
  always_comb begin
    lit   = (state_q == S_SHOW) && !blank[idx_q] && !lz_blank[idx_q];
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (lit) begin
      an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
      seg_d = hex7(nibs[idx_q]) ^ SEG_OFF;
      dp_d  = dp_in[idx_q] ^ DP_OFF;
    end
  end

  // State and registered display outputs; outputs lag the state by one cycle.
  always_ff @(posedge fastclock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      cnt_q   <= '0;
      an      <= AN_OFF;
      seg     <= SEG_OFF;
      dp      <= DP_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      an      <= an_d;
      seg     <= seg_d;
      dp      <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (NUM_DIGITS=4, BLANK_CYCLES=2, ACTIVE_LOW=1).
// Random ticks, values, dp and blank requests. A timing-based reference
// model pushes the expected display for every clock edge into a queue.
// A monitor pops and compares those entries 1 ns after each edge.
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int B = 2;

  logic        fastclock = 1'b0;
  logic        reset     = 1'b0;
  logic        tick      = 1'b0;
  logic [15:0] value     = 16'h0;
  logic [3:0]  dp_in     = 4'h0;
  logic [3:0]  blank     = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg7_scan_driver #(.NUM_DIGITS(N), .BLANK_CYCLES(B), .ACTIVE_LOW(1'b1)) dut (
    .fastclock(fastclock), .reset(reset), .tick(tick), .value(value),
    .dp_in(dp_in), .blank(blank), .an(an), .seg(seg), .dp(dp)
  );

  always #5 fastclock = ~fastclock;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: described by event times rather than states.
  bit          started   = 0;
  int          slot      = 0;   // digit slots shown since the last restart
  int          show_from = 0;   // edge at which the current slot's dark gap ended
  bit          cap_pend  = 0;
  int          cap_edge  = 0;
  logic [15:0] snap      = 16'h0;
  int          cyc       = 0;   // index of the next clock edge

  // Push the expectation for the next edge, update the model, then run that edge.
  task automatic step();
    exp_t        e;
    int          d;
    bit          off;
    logic [15:0] sh;
    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.cyc = cyc;
    if (reset && started && show_from <= cyc - 1) begin
      d   = slot % N;
      sh  = snap >> (4 * d);
      off = blank[d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (d != 0 && sh == 16'h0) off = 1'b1;
`endif
      if (!off) begin
        e.an  = ~(4'b0001 << d);
        e.seg = ~hex_tbl[sh[3:0]];
        e.dp  = ~dp_in[d];
      end
    end
    sb.push_back(e);
    if (!reset) begin
      started  = 0;
      cap_pend = 0;
    end else begin
      if (tick) begin
        if (!started) begin
          started = 1; slot = 0; show_from = cyc; snap = value;
        end else if (cyc > show_from) begin
          slot++;
          show_from = cyc + B;
          if (slot % N == 0) begin cap_pend = 1; cap_edge = cyc + B; end
        end
      end
      if (cap_pend && cyc == cap_edge) begin snap = value; cap_pend = 0; end
    end
    @(posedge fastclock);
    #3;
    cyc++;
  endtask

  // Monitor: compare the registered outputs 1 ns after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge fastclock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
          n_bad++;
          $display("FAIL display edge %0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                   e.cyc, an, seg, dp, e.an, e.seg, e.dp);
        end else begin
          $display("edge %0d: an=%h seg=%h dp=%b ok", e.cyc, an, seg, dp);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int cd;
    cd = 0;
    repeat (2) @(posedge fastclock);
    #3;
    reset = 1'b1;
    // Idle after reset: no tick, display must stay dark.
    for (int i = 0; i < 10; i++) step();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1000 || i == 2100) begin
        reset = 1'b0;
        tick  = 1'b0;
        #1;
        n_cmp++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
          n_bad++;
          $display("FAIL async reset: got an=%h seg=%h dp=%b, expected an=f seg=7f dp=1", an, seg, dp);
        end else begin
          $display("async reset at edge %0d: outputs dark ok", cyc);
        end
        repeat (3) step();
        reset = 1'b1;
      end
      tick = (cd == 0) || ($urandom_range(0, 9) == 0);
      if (cd == 0) cd = $urandom_range(4, 9);
      else cd--;
      if ($urandom_range(0, 19) == 0) value = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank = 4'($urandom) & 4'($urandom);
      step();
    end
    tick = 1'b0;
    repeat (2) step();
    @(posedge fastclock);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
